// File: rtl/spike_gen_scheduler.sv
// spike_gen_scheduler: table of programmable periodic spike generators.
// Every time-unit pulse triggers one sweep over slots 0..conf_gens_used; each
// enabled slot counts down and, on expiry, emits its tag with a +1/-1 count.
// Optional build macro: SPIKE_GEN_SCHED_OVERRUN_CNT_EN adds a saturating
// 16-bit counter of dropped time-unit pulses (otherwise overrun_count is 0).
module spike_gen_scheduler #(
  parameter int unsigned Ngens   = 8,
  parameter int unsigned Nperiod = 16,
  parameter int unsigned Ntag    = 11,
  parameter int unsigned Nct     = 9
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  time_unit_pulse,
  input  logic [Ngens-1:0]      conf_gens_used,
  input  logic [(2**Ngens)-1:0] conf_gens_en,
  input  logic [Ngens-1:0]      prog_gen_idx,
  input  logic [Nperiod-1:0]    prog_period,
  input  logic [Nperiod-1:0]    prog_ticks,
  input  logic [Ntag-1:0]       prog_tag,
  input  logic                  prog_sign,
  input  logic                  prog_v,
  output logic                  prog_a,
  output logic [Ntag-1:0]       out_tag,
  output logic [Nct-1:0]        out_ct,
  output logic                  out_v,
  input  logic                  out_a,
  output logic                  busy,
  output logic                  overrun,
  output logic [15:0]           overrun_count
);

  localparam int unsigned Nslots = 2**Ngens;

  typedef enum logic [1:0] {IDLE, READ, UPDATE, EMIT} state_t;

  typedef struct packed {
    logic [Nperiod-1:0] period;
    logic [Nperiod-1:0] ticks;
    logic [Ntag-1:0]    tag;
    logic               sign;
  } slot_t;

  logic [1:0]        rst_sync_q;
  logic              rst_n;

  state_t            state_q, state_d;
  logic [Ngens-1:0]  idx_q;
  logic [Ngens-1:0]  used_q;
  logic [Nslots-1:0] en_q;
  logic              pending_q, pending_d;
  logic              prog_a_q;
  logic              busy_q;
  logic              out_v_q;
  logic              overrun_q;
  logic [Ntag-1:0]   out_tag_q;
  logic [Nct-1:0]    out_ct_q;

  slot_t             mem_q [Nslots];
  slot_t             rd_q;

  logic              accept, start, active, expire, last, advance, drop;
  logic              mem_we;
  logic [Ngens-1:0]  mem_waddr;
  slot_t             mem_wdata;

  // Reset synchronizer: assert asynchronously, release on the second clk edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= '0;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  // Next-state, pulse bookkeeping and handshake decode.
  always_comb begin
    accept  = (state_q == IDLE) && prog_v && prog_a_q;
    start   = (state_q == IDLE) && !prog_v && (time_unit_pulse || pending_q);
    active  = en_q[idx_q] && (rd_q.period != '0);
    expire  = active && (rd_q.ticks == '0);
    last    = (idx_q >= used_q);
    advance = ((state_q == UPDATE) && !expire) || ((state_q == EMIT) && out_a);

    // A start consumes the pending pulse first; a coincident fresh pulse then
    // becomes the new pending one. Otherwise a pulse is queued or dropped.
    pending_d = pending_q;
    drop      = 1'b0;
    if (start) begin
      pending_d = pending_q && time_unit_pulse;
    end else if (time_unit_pulse) begin
      if (pending_q) drop      = 1'b1;
      else           pending_d = 1'b1;
    end

    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = READ;
      READ:    state_d = UPDATE;
      UPDATE:  if (expire) state_d = EMIT;
      EMIT:    state_d = EMIT;
      default: state_d = IDLE;
    endcase
    if (advance) state_d = last ? IDLE : READ;
  end

  // Single write port shared by programming (IDLE) and tick update (UPDATE).
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = idx_q;
    mem_wdata = rd_q;
    if (accept) begin
      mem_we    = 1'b1;
      mem_waddr = prog_gen_idx;
      mem_wdata = {prog_period, prog_ticks, prog_tag, prog_sign};
    end else if ((state_q == UPDATE) && active) begin
      mem_we          = 1'b1;
      mem_wdata.ticks = expire ? (rd_q.period - 1'b1) : (rd_q.ticks - 1'b1);
    end
  end

  // Slot memory with synchronous read issued in READ; contents are not reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    if (state_q == READ) rd_q <= mem_q[idx_q];
  end

  // Sweep FSM with registered handshake, status and emit outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      used_q    <= '0;
      en_q      <= '0;
      pending_q <= 1'b0;
      prog_a_q  <= 1'b0;
      busy_q    <= 1'b0;
      out_v_q   <= 1'b0;
      overrun_q <= 1'b0;
      out_tag_q <= '0;
      out_ct_q  <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      prog_a_q  <= (state_d == IDLE);
      busy_q    <= (state_d != IDLE);
      if (drop) overrun_q <= 1'b1;

      if (start) begin
        idx_q  <= '0;
        used_q <= conf_gens_used;
        en_q   <= conf_gens_en;
      end else if (advance && !last) begin
        idx_q <= idx_q + 1'b1;
      end

      if ((state_q == UPDATE) && expire) begin
        out_v_q   <= 1'b1;
        out_tag_q <= rd_q.tag;
        out_ct_q  <= rd_q.sign ? '1 : {{(Nct-1){1'b0}}, 1'b1};
      end else if ((state_q == EMIT) && out_a) begin
        out_v_q <= 1'b0;
      end
    end
  end

`ifdef SPIKE_GEN_SCHED_OVERRUN_CNT_EN
  logic [15:0] ovr_cnt_q;

  // Saturating count of dropped time-unit pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              ovr_cnt_q <= '0;
    else if (drop && (ovr_cnt_q != 16'hFFFF)) ovr_cnt_q <= ovr_cnt_q + 16'd1;
  end

  assign overrun_count = ovr_cnt_q;
`else
  assign overrun_count = '0;
`endif

  assign prog_a  = prog_a_q;
  assign busy    = busy_q;
  assign out_v   = out_v_q;
  assign out_tag = out_tag_q;
  assign out_ct  = out_ct_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_spike_gen_scheduler.sv
// Self-checking bench for spike_gen_scheduler (default parameters).
module tb_spike_gen_scheduler;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         time_unit_pulse;
  logic [7:0]   conf_gens_used;
  logic [255:0] conf_gens_en;
  logic [7:0]   prog_gen_idx;
  logic [15:0]  prog_period;
  logic [15:0]  prog_ticks;
  logic [10:0]  prog_tag;
  logic         prog_sign;
  logic         prog_v;
  logic         prog_a;
  logic [10:0]  out_tag;
  logic [8:0]   out_ct;
  logic         out_v;
  logic         out_a;
  logic         busy;
  logic         overrun;
  logic [15:0]  overrun_count;

`ifdef SPIKE_GEN_SCHED_OVERRUN_CNT_EN
  localparam logic [15:0] ExpOvrCnt = 16'd1;
`else
  localparam logic [15:0] ExpOvrCnt = 16'd0;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int unsigned a_mode = 0;  // 0: out_a low, 1: out_a high, 2: random

  logic [19:0] obs_q[$];
  logic [19:0] exp_q[$];

  int unsigned m_per [256];
  int unsigned m_tk  [256];
  logic [10:0] m_tag [256];
  logic        m_sign[256];

  spike_gen_scheduler dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .time_unit_pulse(time_unit_pulse),
    .conf_gens_used (conf_gens_used),
    .conf_gens_en   (conf_gens_en),
    .prog_gen_idx   (prog_gen_idx),
    .prog_period    (prog_period),
    .prog_ticks     (prog_ticks),
    .prog_tag       (prog_tag),
    .prog_sign      (prog_sign),
    .prog_v         (prog_v),
    .prog_a         (prog_a),
    .out_tag        (out_tag),
    .out_ct         (out_ct),
    .out_v          (out_v),
    .out_a          (out_a),
    .busy           (busy),
    .overrun        (overrun),
    .overrun_count  (overrun_count)
  );

  always #5 clk = ~clk;

  initial begin
    out_a = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (a_mode)
        0:       out_a = 1'b0;
        1:       out_a = 1'b1;
        default: out_a = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Record every completed output transfer.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && out_v === 1'b1 && out_a === 1'b1)
        obs_q.push_back({out_tag, out_ct});
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  // Behavioural reference: one sweep over the configured slots.
  task automatic model_sweep();
    logic [8:0] ct;
    for (int unsigned i = 0; i <= conf_gens_used; i++) begin
      if (conf_gens_en[i] && m_per[i] != 0) begin
        if (m_tk[i] == 0) begin
          m_tk[i] = m_per[i] - 1;
          ct = m_sign[i] ? 9'h1FF : 9'h001;
          exp_q.push_back({m_tag[i], ct});
        end else begin
          m_tk[i] = m_tk[i] - 1;
        end
      end
    end
  endtask

  task automatic prog(input int unsigned idx, input int unsigned per, input int unsigned tk,
                      input logic [10:0] tag, input logic sg);
    bit ok;
    ok = 0;
    @(posedge clk);
    #1;
    prog_gen_idx = idx[7:0];
    prog_period  = per[15:0];
    prog_ticks   = tk[15:0];
    prog_tag     = tag;
    prog_sign    = sg;
    prog_v       = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (prog_a === 1'b1) begin ok = 1; break; end
    end
    @(posedge clk);
    #1;
    prog_v = 1'b0;
    check("prog_accept", 32'(ok), 32'd1);
    m_per[idx]  = per;
    m_tk[idx]   = tk;
    m_tag[idx]  = tag;
    m_sign[idx] = sg;
  endtask

  task automatic pulse();
    @(posedge clk);
    #1;
    time_unit_pulse = 1'b1;
    @(posedge clk);
    #1;
    time_unit_pulse = 1'b0;
  endtask

  task automatic wait_quiet();
    int  q;
    bit  done;
    q = 0;
    done = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (busy === 1'b0) q++; else q = 0;
      if (q >= 3) begin done = 1; break; end
    end
    check("quiet", 32'(done), 32'd1);
  endtask

  task automatic wait_out_v();
    bit done;
    done = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (out_v === 1'b1) begin done = 1; break; end
    end
    check("out_v_seen", 32'(done), 32'd1);
  endtask

  task automatic compare_queues(input string name);
    check({name, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++)
      check(name, 32'(obs_q[k]), 32'(exp_q[k]));
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int          prev;
    int          cnt;
    logic [8:0]  mask9;
    logic [5:0]  mask6;

    reset_n         = 1'b0;
    time_unit_pulse = 1'b0;
    conf_gens_used  = '0;
    conf_gens_en    = '0;
    prog_gen_idx    = '0;
    prog_period     = '0;
    prog_ticks      = '0;
    prog_tag        = '0;
    prog_sign       = 1'b0;
    prog_v          = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_prog_a", 32'(prog_a), 32'd0);
    check("rst_out_v", 32'(out_v), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_out_tag", 32'(out_tag), 32'd0);
    check("rst_out_ct", 32'(out_ct), 32'd0);
    check("rst_ovr_cnt", 32'(overrun_count), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("idle_prog_a", 32'(prog_a), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);

    // Slot 3, period 4: emits on pulses 1, 5, 9
    a_mode = 1;
    prog(3, 4, 0, 11'h155, 1'b0);
    conf_gens_en    = '0;
    conf_gens_en[3] = 1'b1;
    conf_gens_used  = 8'd3;
    mask9 = '0;
    for (int p = 0; p < 9; p++) begin
      prev = obs_q.size();
      pulse();
      model_sweep();
      wait_quiet();
      if (obs_q.size() > prev) mask9[p] = 1'b1;
    end
    check("period4_mask", 32'(mask9), 32'h111);
    compare_queues("period4");

    // Negative count, output stalled for 10 cycles
    a_mode = 0;
    prog(0, 1, 0, 11'h0AA, 1'b1);
    conf_gens_en   = '0;
    conf_gens_en[0] = 1'b1;
    conf_gens_used = 8'd0;
    pulse();
    model_sweep();
    wait_out_v();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("stall_out_v", 32'(out_v), 32'd1);
      check("stall_out_ct", 32'(out_ct), 32'h1FF);
      check("stall_busy", 32'(busy), 32'd1);
    end
    check("stall_out_tag", 32'(out_tag), 32'h0AA);
    a_mode = 1;
    @(negedge clk);
    check("stall_accept_v", 32'(out_v & out_a), 32'd1);
    @(negedge clk);
    check("stall_done_v", 32'(out_v), 32'd0);
    check("stall_done_busy", 32'(busy), 32'd0);
    wait_quiet();
    compare_queues("neg_stall");

    // Three pulses during one stalled sweep
    a_mode = 0;
    pulse();
    model_sweep();
    wait_out_v();
    pulse();
    model_sweep();
    @(negedge clk);
    check("ovr_after_2nd", 32'(overrun), 32'd0);
    check("busy_after_2nd", 32'(busy), 32'd1);
    pulse();
    @(negedge clk);
    check("ovr_after_3rd", 32'(overrun), 32'd1);
    check("ovr_cnt_after_3rd", 32'(overrun_count), 32'(ExpOvrCnt));
    a_mode = 1;
    wait_quiet();
    compare_queues("overrun_rerun");
    check("ovr_sticky", 32'(overrun), 32'd1);

    // Program word and pulse in the same IDLE cycle
    @(posedge clk);
    #1;
    prog_gen_idx    = 8'd0;
    prog_period     = 16'd1;
    prog_ticks      = 16'd0;
    prog_tag        = 11'h123;
    prog_sign       = 1'b0;
    prog_v          = 1'b1;
    time_unit_pulse = 1'b1;
    @(negedge clk);
    check("coll_prog_a", 32'(prog_a), 32'd1);
    @(posedge clk);
    #1;
    prog_v          = 1'b0;
    time_unit_pulse = 1'b0;
    m_per[0] = 1; m_tk[0] = 0; m_tag[0] = 11'h123; m_sign[0] = 1'b0;
    model_sweep();
    @(negedge clk);
    check("coll_busy_first", 32'(busy), 32'd0);
    @(negedge clk);
    check("coll_busy_next", 32'(busy), 32'd1);
    wait_quiet();
    compare_queues("collision");

    // Configuration is held for the whole sweep
    prog(1, 1, 0, 11'h201, 1'b0);
    a_mode = 0;
    conf_gens_en    = '0;
    conf_gens_en[1:0] = 2'b11;
    conf_gens_used  = 8'd1;
    pulse();
    model_sweep();
    wait_out_v();
    conf_gens_en   = '0;
    conf_gens_used = 8'd0;
    a_mode = 1;
    wait_quiet();
    compare_queues("conf_hold");

    // Disabled slot and zero-period slot: no emission, ticks preserved
    prog(5, 2, 3, 11'h055, 1'b0);
    prog(6, 0, 0, 11'h066, 1'b0);
    conf_gens_en    = '0;
    conf_gens_en[6] = 1'b1;
    conf_gens_used  = 8'd6;
    pulse();
    model_sweep();
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (busy === 1'b1) cnt++; else break;
    end
    check("sweep_cycles_7slots", 32'(cnt), 32'd14);
    wait_quiet();
    for (int p = 1; p < 20; p++) begin
      pulse();
      model_sweep();
      wait_quiet();
    end
    check("disabled_no_emit", 32'(obs_q.size()), 32'd0);
    compare_queues("disabled");
    conf_gens_en[5] = 1'b1;
    mask6 = '0;
    for (int p = 0; p < 6; p++) begin
      prev = obs_q.size();
      pulse();
      model_sweep();
      wait_quiet();
      if (obs_q.size() > prev) mask6[p] = 1'b1;
    end
    check("enabled_mask", 32'(mask6), 32'h28);
    compare_queues("enabled");

    // Randomized programming, enables and output back-pressure
    a_mode = 2;
    for (int s = 0; s < 8; s++)
      prog(s, $urandom_range(0, 4), $urandom_range(0, 4), 11'($urandom), 1'($urandom));
    conf_gens_used = 8'd7;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 2) == 0)
        prog($urandom_range(0, 7), $urandom_range(0, 4), $urandom_range(0, 4),
             11'($urandom), 1'($urandom));
      conf_gens_en      = '0;
      conf_gens_en[7:0] = 8'($urandom);
      pulse();
      model_sweep();
      wait_quiet();
    end
    compare_queues("random");

    // Reset asserted mid-EMIT
    a_mode = 0;
    prog(0, 1, 0, 11'h3C3, 1'b0);
    conf_gens_en    = '0;
    conf_gens_en[0] = 1'b1;
    conf_gens_used  = 8'd0;
    pulse();
    wait_out_v();
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_emit_out_v", 32'(out_v), 32'd0);
    check("rst_emit_busy", 32'(busy), 32'd0);
    check("rst_emit_prog_a", 32'(prog_a), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("post_rst_prog_a", 32'(prog_a), 32'd1);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_out_v", 32'(out_v), 32'd0);
    check("post_rst_overrun", 32'(overrun), 32'd0);
    check("post_rst_ovr_cnt", 32'(overrun_count), 32'd0);
    check("post_rst_no_xfer", 32'(obs_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
